// File: rtl/cpu15_seq.sv
// cpu15_seq: instruction-phase sequencer and run controller for the cpu15
// four-stage datapath (fetch, decode, execute, writeback).
//
// Ports:
//   clk_i          system clock, all state updates on the rising edge
//   reset_i        synchronous active-high reset
//   run_req_i      pulse: start continuous execution
//   stop_req_i     pulse: stop at the next instruction boundary
//   step_req_i     pulse: execute exactly one instruction
//   halt_op_i      decoded halt opcode, sampled only in the execute phase
//   dbg_req_i      level: host requests datapath access
//   en_ft_o..en_wb_o  one-hot phase enables
//   busy_o         an instruction is in flight
//   halted_o       core is stopped at an instruction boundary
//   dbg_gnt_o      host owns the datapath
//   halt_cause_o   0 reset, 1 halt opcode, 2 stop/step/debug, 3 run limit
//   instr_cnt_o    retired-instruction count (wraps)
module cpu15_seq #(
    parameter bit          START_RUNNING = 1'b0,
    parameter int unsigned RUN_LIMIT     = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             run_req_i,
    input  logic             stop_req_i,
    input  logic             step_req_i,
    input  logic             halt_op_i,
    input  logic             dbg_req_i,
    output logic             en_ft_o,
    output logic             en_dc_o,
    output logic             en_ex_o,
    output logic             en_wb_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             dbg_gnt_o,
    output logic [1:0]       halt_cause_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_DEBUG  = 2'd3
    } state_e;

    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH_FT   = 4'b0001;
    localparam logic [3:0] PH_DC   = 4'b0010;
    localparam logic [3:0] PH_EX   = 4'b0100;
    localparam logic [3:0] PH_WB   = 4'b1000;

    localparam logic [1:0] CAUSE_RESET = 2'd0;
    localparam logic [1:0] CAUSE_HALT  = 2'd1;
    localparam logic [1:0] CAUSE_STOP  = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;

    state_e           state_q, state_d;
    logic [3:0]       phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             gnt_q, gnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic             pend_q, pend_d;
    logic             hop_q, hop_d;

    logic [CNT_W-1:0] lim_inc;
    logic             limit_hit;
    logic             stop_now;

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= START_RUNNING ? S_RUN : S_HALTED;
            phase_q  <= PH_IDLE;
            busy_q   <= 1'b0;
            halted_q <= !START_RUNNING;
            gnt_q    <= 1'b0;
            cause_q  <= CAUSE_RESET;
            cnt_q    <= '0;
            lim_q    <= '0;
            pend_q   <= 1'b0;
            hop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            gnt_q    <= gnt_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            pend_q   <= pend_d;
            hop_q    <= hop_d;
        end
    end

    // Next-state, phase sequencing and boundary stop decision.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        halted_d = halted_q;
        gnt_d    = gnt_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        pend_d   = pend_q;
        hop_d    = hop_q;

        lim_inc   = lim_q + CNT_W'(1);
        limit_hit = (RUN_LIMIT != 0) && (lim_inc == CNT_W'(RUN_LIMIT));
        stop_now  = 1'b0;

        unique case (state_q)
            S_HALTED: begin
                if (dbg_req_i) begin
                    state_d = S_DEBUG;
                    gnt_d   = 1'b1;
                end else if (run_req_i || step_req_i) begin
                    // RUN wins over STEP when both arrive together.
                    state_d  = run_req_i ? S_RUN : S_STEP;
                    phase_d  = PH_FT;
                    halted_d = 1'b0;
                    lim_d    = '0;
                    pend_d   = 1'b0;
                    hop_d    = 1'b0;
                end
            end

            S_RUN, S_STEP: begin
                if (stop_req_i || dbg_req_i) begin
                    pend_d = 1'b1;
                end
                if ((phase_q == PH_EX) && halt_op_i) begin
                    hop_d = 1'b1;
                end
                case (phase_q)
                    PH_FT: phase_d = PH_DC;
                    PH_DC: phase_d = PH_EX;
                    PH_EX: phase_d = PH_WB;
                    PH_WB: begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        lim_d    = lim_inc;
                        stop_now = hop_q || limit_hit || pend_q || stop_req_i
                                   || dbg_req_i || (state_q == S_STEP);
                        hop_d    = 1'b0;
                        if (stop_now) begin
                            phase_d  = PH_IDLE;
                            halted_d = 1'b1;
                            pend_d   = 1'b0;
                            // A debug stop goes straight to DEBUG; grant follows a cycle later.
                            state_d  = dbg_req_i ? S_DEBUG : S_HALTED;
                            if (hop_q) begin
                                cause_d = CAUSE_HALT;
                            end else if (limit_hit) begin
                                cause_d = CAUSE_LIMIT;
                            end else begin
                                cause_d = CAUSE_STOP;
                            end
                        end else begin
                            phase_d = PH_FT;
                        end
                    end
                    // Idle phase in RUN only occurs straight out of reset.
                    default: phase_d = PH_FT;
                endcase
            end

            S_DEBUG: begin
                if (dbg_req_i) begin
                    gnt_d = 1'b1;
                end else begin
                    gnt_d   = 1'b0;
                    state_d = S_HALTED;
                end
            end

            default: state_d = S_HALTED;
        endcase

        busy_d = |phase_d;
    end

    assign en_ft_o      = phase_q[0];
    assign en_dc_o      = phase_q[1];
    assign en_ex_o      = phase_q[2];
    assign en_wb_o      = phase_q[3];
    assign busy_o       = busy_q;
    assign halted_o     = halted_q;
    assign dbg_gnt_o    = gnt_q;
    assign halt_cause_o = cause_q;
    assign instr_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cpu15_seq.sv
// Directed bench for cpu15_seq: instance A uses the defaults (halted out of
// reset, no run limit); instance B starts running with RUN_LIMIT=5, CNT_W=4.
module tb_cpu15_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        rst_a, run_a, stop_a, step_a, hop_a, dbg_a;
    logic        ft_a, dc_a, ex_a, wb_a, busy_a, halted_a, gnt_a;
    logic [1:0]  cause_a;
    logic [15:0] cnt_a;

    // Instance B signals
    logic        rst_b, run_b, stop_b, step_b, hop_b, dbg_b;
    logic        ft_b, dc_b, ex_b, wb_b, busy_b, halted_b, gnt_b;
    logic [1:0]  cause_b;
    logic [3:0]  cnt_b;

    int n_vec = 0;
    int n_err = 0;

    cpu15_seq #(.START_RUNNING(1'b0), .RUN_LIMIT(0), .CNT_W(16)) u_a (
        .clk_i(clk), .reset_i(rst_a), .run_req_i(run_a), .stop_req_i(stop_a),
        .step_req_i(step_a), .halt_op_i(hop_a), .dbg_req_i(dbg_a),
        .en_ft_o(ft_a), .en_dc_o(dc_a), .en_ex_o(ex_a), .en_wb_o(wb_a),
        .busy_o(busy_a), .halted_o(halted_a), .dbg_gnt_o(gnt_a),
        .halt_cause_o(cause_a), .instr_cnt_o(cnt_a)
    );

    cpu15_seq #(.START_RUNNING(1'b1), .RUN_LIMIT(5), .CNT_W(4)) u_b (
        .clk_i(clk), .reset_i(rst_b), .run_req_i(run_b), .stop_req_i(stop_b),
        .step_req_i(step_b), .halt_op_i(hop_b), .dbg_req_i(dbg_b),
        .en_ft_o(ft_b), .en_dc_o(dc_b), .en_ex_o(ex_b), .en_wb_o(wb_b),
        .busy_o(busy_b), .halted_o(halted_b), .dbg_gnt_o(gnt_b),
        .halt_cause_o(cause_b), .instr_cnt_o(cnt_b)
    );

    // Advance one cycle; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed {wb,ex,dc,ft} for instance A / B.
    function automatic logic [31:0] ph_a();
        return 32'({wb_a, ex_a, dc_a, ft_a});
    endfunction
    function automatic logic [31:0] ph_b();
        return 32'({wb_b, ex_b, dc_b, ft_b});
    endfunction

    // Let instance B run until it halts, counting writeback pulses.
    task automatic run_b_until_halt(output int wbs);
        wbs = 0;
        for (int k = 0; k < 60 && !halted_b; k++) begin
            if (wb_b) wbs++;
            tick();
        end
        chk("b_halt_timeout", 32'(halted_b), 32'd1);
    endtask

    initial begin
        int wbs;
        rst_a = 1'b1; run_a = 1'b0; stop_a = 1'b0; step_a = 1'b0; hop_a = 1'b0; dbg_a = 1'b0;
        rst_b = 1'b1; run_b = 1'b0; stop_b = 1'b0; step_b = 1'b0; hop_b = 1'b0; dbg_b = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("a_rst_phase",  ph_a(), 32'd0);
        chk("a_rst_halted", 32'(halted_a), 32'd1);
        chk("a_rst_busy",   32'(busy_a), 32'd0);
        chk("a_rst_gnt",    32'(gnt_a), 32'd0);
        chk("a_rst_cnt",    32'(cnt_a), 32'd0);
        chk("a_rst_cause",  32'(cause_a), 32'd0);
        chk("b_rst_halted", 32'(halted_b), 32'd0);
        chk("b_rst_phase",  ph_b(), 32'd0);

        // Release A at cycle 0, RUN_REQ at cycle 10
        rst_a = 1'b0;
        repeat (10) tick();
        chk("a_idle_halted", 32'(halted_a), 32'd1);
        run_a = 1'b1;
        tick();                                   // cycle 11
        run_a = 1'b0;
        chk("a_c11_ft",     ph_a(), 32'h1);
        chk("a_c11_halted", 32'(halted_a), 32'd0);
        chk("a_c11_busy",   32'(busy_a), 32'd1);
        tick(); chk("a_c12_dc", ph_a(), 32'h2);
        tick(); chk("a_c13_ex", ph_a(), 32'h4);
        tick(); chk("a_c14_wb", ph_a(), 32'h8);
        chk("a_c14_cnt", 32'(cnt_a), 32'd0);
        tick(); chk("a_c15_ft", ph_a(), 32'h1);
        chk("a_c15_cnt", 32'(cnt_a), 32'd1);
        repeat (4) tick();                        // cycle 19
        chk("a_c19_ft",  ph_a(), 32'h1);
        chk("a_c19_cnt", 32'(cnt_a), 32'd2);

        // STOP_REQ during DC of instruction 3
        tick();                                   // cycle 20 DC
        stop_a = 1'b1;
        tick();                                   // cycle 21 EX
        stop_a = 1'b0;
        chk("a_stop_ex", ph_a(), 32'h4);
        tick(); chk("a_stop_wb", ph_a(), 32'h8);
        tick();                                   // cycle 23
        chk("a_stop_halted", 32'(halted_a), 32'd1);
        chk("a_stop_phase",  ph_a(), 32'd0);
        chk("a_stop_cnt",    32'(cnt_a), 32'd3);
        chk("a_stop_cause",  32'(cause_a), 32'd2);
        tick();
        chk("a_stop_noft", ph_a(), 32'd0);

        // STEP with HALT_OP in EX
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        chk("a_step_ft", ph_a(), 32'h1);
        tick();
        tick();
        chk("a_step_ex", ph_a(), 32'h4);
        hop_a = 1'b1;
        tick();
        hop_a = 1'b0;
        chk("a_step_wb", ph_a(), 32'h8);
        tick();
        chk("a_step_halted", 32'(halted_a), 32'd1);
        chk("a_step_cnt",    32'(cnt_a), 32'd4);
        chk("a_step_cause",  32'(cause_a), 32'd1);

        // RUN and STEP together -> continuous run
        run_a = 1'b1; step_a = 1'b1;
        tick();
        run_a = 1'b0; step_a = 1'b0;
        chk("a_rs_ft", ph_a(), 32'h1);
        repeat (4) tick();
        chk("a_rs_cont_ft", ph_a(), 32'h1);
        chk("a_rs_halted",  32'(halted_a), 32'd0);
        chk("a_rs_cnt",     32'(cnt_a), 32'd5);

        // DBG_REQ during RUN; HALT_OP outside EX must be ignored
        dbg_a = 1'b1; hop_a = 1'b1;
        tick();                                   // DC
        tick();                                   // EX
        hop_a = 1'b0;
        chk("a_dbg_ex",  ph_a(), 32'h4);
        chk("a_dbg_gnt_ex", 32'(gnt_a), 32'd0);
        tick();
        chk("a_dbg_wb", ph_a(), 32'h8);
        tick();
        chk("a_dbg_halted", 32'(halted_a), 32'd1);
        chk("a_dbg_phase",  ph_a(), 32'd0);
        chk("a_dbg_gnt0",   32'(gnt_a), 32'd0);
        chk("a_dbg_cnt",    32'(cnt_a), 32'd6);
        chk("a_dbg_cause",  32'(cause_a), 32'd2);
        tick();
        chk("a_dbg_gnt1",    32'(gnt_a), 32'd1);
        chk("a_dbg_halted1", 32'(halted_a), 32'd1);
        run_a = 1'b1;
        tick();
        run_a = 1'b0; step_a = 1'b1;
        tick();
        step_a = 1'b0;
        tick();
        chk("a_dbg_ign_phase", ph_a(), 32'd0);
        chk("a_dbg_ign_gnt",   32'(gnt_a), 32'd1);
        chk("a_dbg_ign_busy",  32'(busy_a), 32'd0);
        dbg_a = 1'b0;
        tick();
        chk("a_dbg_drop_gnt",    32'(gnt_a), 32'd0);
        chk("a_dbg_drop_halted", 32'(halted_a), 32'd1);

        // RESET during EX
        run_a = 1'b1;
        tick();
        run_a = 1'b0;
        chk("a_rr_ft", ph_a(), 32'h1);
        tick();
        tick();
        chk("a_rr_ex", ph_a(), 32'h4);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("a_rr_phase",  ph_a(), 32'd0);
        chk("a_rr_cnt",    32'(cnt_a), 32'd0);
        chk("a_rr_cause",  32'(cause_a), 32'd0);
        chk("a_rr_halted", 32'(halted_a), 32'd1);

        // Instance B: starts running, limit of 5 per run, 4-bit counter
        rst_b = 1'b0;
        tick();
        chk("b_start_ft",     ph_b(), 32'h1);
        chk("b_start_halted", 32'(halted_b), 32'd0);
        run_b_until_halt(wbs);
        chk("b_run1_wbs",   32'(wbs), 32'd5);
        chk("b_run1_cause", 32'(cause_b), 32'd3);
        chk("b_run1_cnt",   32'(cnt_b), 32'd5);
        run_b = 1'b1; tick(); run_b = 1'b0;
        run_b_until_halt(wbs);
        chk("b_run2_wbs", 32'(wbs), 32'd5);
        chk("b_run2_cnt", 32'(cnt_b), 32'd10);
        run_b = 1'b1; tick(); run_b = 1'b0;
        run_b_until_halt(wbs);
        chk("b_run3_cnt", 32'(cnt_b), 32'd15);

        // Fourth run crosses the counter wrap 15 -> 0 -> 1
        run_b = 1'b1; tick(); run_b = 1'b0;
        chk("b_wrap_ft",  ph_b(), 32'h1);
        chk("b_wrap_15",  32'(cnt_b), 32'd15);
        repeat (4) tick();
        chk("b_wrap_0",   32'(cnt_b), 32'd0);
        repeat (4) tick();
        chk("b_wrap_1",   32'(cnt_b), 32'd1);
        run_b_until_halt(wbs);
        chk("b_run4_wbs",   32'(wbs), 32'd3);
        chk("b_run4_cnt",   32'(cnt_b), 32'd4);
        chk("b_run4_cause", 32'(cause_b), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
